prbs_gen_chk: RTL and testbench

- Parametrised PRBS pattern generator and self-synchronising checker; the next generation of the single-mode PRBS31 tile.
- Generates DATA_W bits per clock in one of four selectable ITU-style polynomials.
- Checks a received stream against the same polynomial, with lock detection and a saturating bit-error counter.
- Sits between the tile pin wrapper and the I/O pins, for link and loopback testing.

---
 rtl/prbs_gen_chk_pkg.sv | 74 +++++++
 rtl/prbs_gen_chk_if.sv | 48 ++++
 rtl/prbs_chk.sv | 146 ++++++++++++++
 rtl/prbs_gen_chk.sv | 78 +++++++
 tb/tb_prbs_gen_chk.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/prbs_gen_chk_pkg.sv
// prbs_pkg: PRBS polynomial taps, mode/state enums and the
// multi-bit serial step shared by generator and checker.
package prbs_pkg;

  typedef enum logic [1:0] {
    PRBS7  = 2'b00,
    PRBS15 = 2'b01,
    PRBS23 = 2'b10,
    PRBS31 = 2'b11
  } mode_e;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  localparam int SW = 31;
  localparam logic [SW-1:0] SEED = '1;

  localparam logic [4:0] P7_N  = 5'd7;
  localparam logic [4:0] P7_M  = 5'd6;
  localparam logic [4:0] P15_N = 5'd15;
  localparam logic [4:0] P15_M = 5'd14;
  localparam logic [4:0] P23_N = 5'd23;
  localparam logic [4:0] P23_M = 5'd18;
  localparam logic [4:0] P31_N = 5'd31;
  localparam logic [4:0] P31_M = 5'd28;

  function automatic logic [4:0] tap_n(mode_e m);
    logic [4:0] n;
    n = P31_N;
    unique case (m)
      PRBS7:  n = P7_N;
      PRBS15: n = P15_N;
      PRBS23: n = P23_N;
      PRBS31: n = P31_N;
    endcase
    return n;
  endfunction

  function automatic logic [4:0] tap_m(mode_e m);
    logic [4:0] k;
    k = P31_M;
    unique case (m)
      PRBS7:  k = P7_M;
      PRBS15: k = P15_M;
      PRBS23: k = P23_M;
      PRBS31: k = P31_M;
    endcase
    return k;
  endfunction

  // Feedback bit is shifted into bit 0, so after nbits steps the
  // emitted bits sit in r[nbits-1:0], first-in-time at the top.
  function automatic logic [SW-1:0] prbs_step(
    logic [SW-1:0] s,
    mode_e         m,
    int            nbits
  );
    logic [SW-1:0] r;
    logic [4:0]    n;
    logic [4:0]    k;
    n = tap_n(m);
    k = tap_m(m);
    r = s;
    for (int i = 0; i < SW; i++) begin
      if (i < nbits) begin
        r = {r[SW-2:0], r[n-5'd1] ^ r[k-5'd1]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/prbs_gen_chk_if.sv
// prbs_gen_chk_if: control, pattern and status bundle of the
// PRBS generator/checker tile.
interface prbs_gen_chk_if #(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 16
);

  logic [1:0]           mode;
  logic                 gen_en;
  logic                 gen_inject;
  logic [DATA_W-1:0]    gen_data;
  logic                 gen_valid;
  logic [DATA_W-1:0]    chk_data;
  logic                 chk_valid;
  logic                 err_clr;
  logic                 chk_locked;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 err_sat;

  modport master (
    output mode,
    output gen_en,
    output gen_inject,
    output chk_data,
    output chk_valid,
    output err_clr,
    input  gen_data,
    input  gen_valid,
    input  chk_locked,
    input  err_cnt,
    input  err_sat
  );

  modport slave (
    input  mode,
    input  gen_en,
    input  gen_inject,
    input  chk_data,
    input  chk_valid,
    input  err_clr,
    output gen_data,
    output gen_valid,
    output chk_locked,
    output err_cnt,
    output err_sat
  );

endinterface

// File: rtl/prbs_chk.sv
// prbs_chk: self-synchronising PRBS checker with lock FSM and a
// saturating bit-error counter.
module prbs_chk
  import prbs_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ERR_CNT_W  = 16,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  mode_e                mode_i,
  input  logic                 mode_chg_i,
  input  logic [DATA_W-1:0]    chk_data_i,
  input  logic                 chk_valid_i,
  input  logic                 err_clr_i,
  output logic                 chk_locked_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic                 err_sat_o
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam int AW = (ERR_CNT_W > 6 ? ERR_CNT_W : 6) + 1;
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] BAD_LAST = BW'(UNLOCK_CNT - 1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  chk_state_e           state_q, state_d;
  logic [SW-1:0]        hist_q, hist_d, hist_w;
  logic [5:0]           rcv_q, rcv_d, rcv_w;
  logic [GW-1:0]        good_q, good_d;
  logic [BW-1:0]        bad_q, bad_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic                 sat_q, sat_d;
  logic [DATA_W-1:0]    err_w;
  logic [5:0]           pop_w;
  logic [AW-1:0]        sum_w;

  // Predict each bit from received history, MSB first in time
  always_comb begin
    logic [SW-1:0] h;
    logic [SW-1:0] p;
    logic [5:0]    n;
    logic [5:0]    tn;
    h     = hist_q;
    n     = rcv_q;
    p     = '0;
    tn    = {1'b0, tap_n(mode_i)};
    err_w = '0;
    pop_w = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      p        = prbs_step(h, mode_i, 1);
      err_w[i] = (chk_data_i[i] ^ p[0]) & (n >= tn);
      pop_w    = pop_w + {5'd0, err_w[i]};
      h        = {p[SW-1:1], chk_data_i[i]};
      if (n != 6'd31) n = n + 6'd1;
    end
    hist_w = h;
    rcv_w  = n;
  end

  assign sum_w = AW'(cnt_q) + AW'(pop_w);

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    rcv_d   = rcv_q;
    good_d  = good_q;
    bad_d   = bad_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (mode_chg_i) begin
      state_d = HUNT;
      hist_d  = '0;
      rcv_d   = '0;
      good_d  = '0;
      bad_d   = '0;
    end else if (chk_valid_i) begin
      hist_d = hist_w;
      rcv_d  = rcv_w;
      unique case (state_q)
        HUNT: begin
          if (|err_w) begin
            good_d = '0;
          end else if (good_q == GOOD_LAST) begin
            state_d = LOCKED;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
        LOCKED: begin
          if (sum_w >= AW'(CNT_MAX)) begin
            cnt_d = CNT_MAX;
            sat_d = 1'b1;
          end else begin
            cnt_d = sum_w[ERR_CNT_W-1:0];
          end
          if (!(|err_w)) begin
            bad_d = '0;
          end else if (bad_q == BAD_LAST) begin
            // Re-mask the history window on the way back to HUNT
            state_d = HUNT;
            bad_d   = '0;
            good_d  = '0;
            rcv_d   = '0;
          end else begin
            bad_d = bad_q + 1'b1;
          end
        end
      endcase
    end
    if (err_clr_i) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      hist_q  <= '0;
      rcv_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      rcv_q   <= rcv_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign chk_locked_o = (state_q == LOCKED);
  assign err_cnt_o    = cnt_q;
  assign err_sat_o    = sat_q;

endmodule

// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: four-polynomial PRBS word generator plus the
// received-stream checker, for link and loopback testing.
module prbs_gen_chk
  import prbs_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ERR_CNT_W  = 16,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  prbs_gen_chk_if.slave bus
);

  mode_e             mode_w;
  mode_e             mode_q;
  logic              mode_chg;
  logic [SW-1:0]     lfsr_q, lfsr_d;
  logic [SW-1:0]     step_w;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  assign mode_w   = mode_e'(bus.mode);
  assign mode_chg = (mode_w != mode_q);
  assign step_w   = prbs_step(lfsr_q, mode_w, DATA_W);

  // A mode switch reseeds and skips one word
  always_comb begin
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (mode_chg) begin
      lfsr_d = SEED;
    end else if (bus.gen_en) begin
      lfsr_d  = step_w;
      data_d  = step_w[DATA_W-1:0];
      data_d[DATA_W-1] = step_w[DATA_W-1] ^ bus.gen_inject;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= PRBS7;
      lfsr_q  <= SEED;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      mode_q  <= mode_w;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.gen_data  = data_q;
  assign bus.gen_valid = valid_q;

  prbs_chk #(
    .DATA_W     (DATA_W),
    .ERR_CNT_W  (ERR_CNT_W),
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT)
  ) u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode_i       (mode_w),
    .mode_chg_i   (mode_chg),
    .chk_data_i   (bus.chk_data),
    .chk_valid_i  (bus.chk_valid),
    .err_clr_i    (bus.err_clr),
    .chk_locked_o (bus.chk_locked),
    .err_cnt_o    (bus.err_cnt),
    .err_sat_o    (bus.err_sat)
  );

endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb_prbs_gen_chk: generator vectors, scoreboarded word stream and
// checker lock/error/saturation sequences on two counter widths.
module tb_prbs_gen_chk;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          gen_en = 1'b0;
  logic          gen_inject = 1'b0;
  logic          err_clr = 1'b0;
  logic          lb = 1'b0;
  logic [DW-1:0] tb_data = '0;
  logic          tb_valid = 1'b0;
  logic [DW-1:0] chk_data;
  logic          chk_valid;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [31:0]   m_s;
  logic [1:0]    m_mq;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  prbs_gen_chk_if #(.DATA_W(DW), .ERR_CNT_W(16)) ifa ();
  prbs_gen_chk_if #(.DATA_W(DW), .ERR_CNT_W(4))  ifb ();

  assign chk_data  = lb ? ifa.gen_data : tb_data;
  assign chk_valid = lb ? ifa.gen_valid : tb_valid;

  assign ifa.mode       = mode;
  assign ifa.gen_en     = gen_en;
  assign ifa.gen_inject = gen_inject;
  assign ifa.chk_data   = chk_data;
  assign ifa.chk_valid  = chk_valid;
  assign ifa.err_clr    = err_clr;
  assign ifb.mode       = mode;
  assign ifb.gen_en     = gen_en;
  assign ifb.gen_inject = gen_inject;
  assign ifb.chk_data   = chk_data;
  assign ifb.chk_valid  = chk_valid;
  assign ifb.err_clr    = err_clr;

  prbs_gen_chk #(
    .DATA_W(DW), .ERR_CNT_W(16), .LOCK_CNT(8), .UNLOCK_CNT(4)
  ) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  prbs_gen_chk #(
    .DATA_W(DW), .ERR_CNT_W(4), .LOCK_CNT(8), .UNLOCK_CNT(4)
  ) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  typedef struct {
    logic [1:0]    mode;
    logic          en;
    logic          inj;
    logic          exp_v;
    logic [DW-1:0] exp_d;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Serial reference LFSR, straight from the polynomial definition
  task automatic ref_word(output logic [DW-1:0] w);
    int   n;
    int   m;
    logic b;
    case (mode)
      2'b00:   begin n = 7;  m = 6;  end
      2'b01:   begin n = 15; m = 14; end
      2'b10:   begin n = 23; m = 18; end
      default: begin n = 31; m = 28; end
    endcase
    w = '0;
    for (int k = 0; k < DW; k++) begin
      b   = m_s[n-1] ^ m_s[m-1];
      m_s = {m_s[30:0], b};
      w   = {w[DW-2:0], b};
    end
  endtask

  task automatic cyc();
    logic [DW-1:0] w;
    logic [DW-1:0] e;
    if (mode != m_mq) begin
      m_s  = '1;
      m_mq = mode;
    end else if (gen_en) begin
      ref_word(w);
      if (gen_inject) w[DW-1] = ~w[DW-1];
      sb.push_back(w);
    end
    @(posedge clk);
    #1;
    if (ifa.gen_valid) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_word", 32'(ifa.gen_valid), 0);
      end else begin
        e = sb.pop_front();
        chk("gen_sb", 32'(ifa.gen_data), 32'(e));
      end
    end
  endtask

  task automatic wait_lock(output int nv);
    nv = 0;
    for (int k = 0; k < 60; k++) begin
      if (chk_valid) nv++;
      cyc();
      if (ifa.chk_locked) break;
    end
    chk("lock_a", 32'(ifa.chk_locked), 1);
    chk("lock_b", 32'(ifb.chk_locked), 1);
  endtask

  initial begin
    int nv;
    int e0;
    int pv;

    tbl[0] = '{2'b00, 1'b1, 1'b0, 1'b1, 8'h02};
    tbl[1] = '{2'b00, 1'b1, 1'b0, 1'b1, 8'h0C};
    tbl[2] = '{2'b00, 1'b0, 1'b0, 1'b0, 8'h0C};
    tbl[3] = '{2'b00, 1'b1, 1'b1, 1'b1, 8'hA8};
    tbl[4] = '{2'b00, 1'b1, 1'b0, 1'b1, 8'hF2};
    tbl[5] = '{2'b01, 1'b1, 1'b0, 1'b0, 8'hF2};
    tbl[6] = '{2'b01, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[7] = '{2'b01, 1'b1, 1'b0, 1'b1, 8'h02};

    m_s  = '1;
    m_mq = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gen_valid", 32'(ifa.gen_valid), 0);
    chk("rst_gen_data", 32'(ifa.gen_data), 0);
    chk("rst_locked", 32'(ifa.chk_locked), 0);
    chk("rst_err_cnt", 32'(ifa.err_cnt), 0);
    chk("rst_err_sat", 32'(ifa.err_sat), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      mode       = tbl[i].mode;
      gen_en     = tbl[i].en;
      gen_inject = tbl[i].inj;
      cyc();
      chk($sformatf("vec%0d_valid", i), 32'(ifa.gen_valid),
          32'(tbl[i].exp_v));
      chk($sformatf("vec%0d_data", i), 32'(ifa.gen_data),
          32'(tbl[i].exp_d));
    end
    gen_inject = 1'b0;

    // PRBS31 loopback: lock, long clean run, single injection
    gen_en = 1'b0;
    lb     = 1'b1;
    mode   = 2'b11;
    cyc();
    gen_en = 1'b1;
    wait_lock(nv);
    chk("lock31_words", 32'(nv), 8);
    repeat (1000) cyc();
    chk("clean_err_cnt", 32'(ifa.err_cnt), 0);
    chk("clean_locked", 32'(ifa.chk_locked), 1);
    gen_inject = 1'b1;
    cyc();
    gen_inject = 1'b0;
    repeat (10) cyc();
    chk("inject_err_cnt", 32'(ifa.err_cnt), 3);
    chk("inject_locked", 32'(ifa.chk_locked), 1);

    // PRBS7 lock, then constant ones
    mode = 2'b00;
    cyc();
    wait_lock(nv);
    chk("lock7_words", 32'(nv), 8);
    lb       = 1'b0;
    tb_data  = '1;
    tb_valid = 1'b0;
    e0       = int'(ifa.err_cnt);
    repeat (3) cyc();
    chk("novalid_err", 32'(ifa.err_cnt), 32'(e0));
    chk("novalid_locked", 32'(ifa.chk_locked), 1);
    tb_valid = 1'b1;
    cyc();
    pv = int'(ifa.err_cnt) - e0;
    chk("ff_w1_delta_range", 32'(pv >= 1 && pv <= 8), 1);
    chk("ff_w1_locked", 32'(ifa.chk_locked), 1);
    for (int k = 2; k <= 4; k++) begin
      pv = int'(ifa.err_cnt);
      cyc();
      chk($sformatf("ff_w%0d_delta", k), 32'(int'(ifa.err_cnt) - pv), 8);
      chk($sformatf("ff_w%0d_locked", k), 32'(ifa.chk_locked),
          32'(k < 4));
    end
    pv = int'(ifa.err_cnt);
    cyc();
    chk("hunt_no_count", 32'(ifa.err_cnt), 32'(pv));
    chk("sat_b_cnt", 32'(ifb.err_cnt), 32'hF);
    chk("sat_b_flag", 32'(ifb.err_sat), 1);

    // err_clr on an errored locked word
    lb = 1'b1;
    wait_lock(nv);
    lb      = 1'b0;
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("clr_a_cnt", 32'(ifa.err_cnt), 0);
    chk("clr_a_sat", 32'(ifa.err_sat), 0);
    chk("clr_b_cnt", 32'(ifb.err_cnt), 0);
    chk("clr_b_sat", 32'(ifb.err_sat), 0);
    cyc();
    chk("post_clr_a", 32'(ifa.err_cnt), 8);
    chk("post_clr_b", 32'(ifb.err_cnt), 8);
    repeat (2) cyc();
    chk("post_clr_unlock", 32'(ifa.chk_locked), 0);
    chk("post_clr_a_end", 32'(ifa.err_cnt), 24);
    chk("post_clr_b_end", 32'(ifb.err_cnt), 32'hF);
    chk("post_clr_b_sat", 32'(ifb.err_sat), 1);

    // Mode change while locked
    lb   = 1'b1;
    mode = 2'b11;
    cyc();
    wait_lock(nv);
    chk("relock31_words", 32'(nv), 8);
    mode = 2'b01;
    cyc();
    chk("mchg_locked", 32'(ifa.chk_locked), 0);
    chk("mchg_gen_valid", 32'(ifa.gen_valid), 0);
    chk("mchg_err_kept", 32'(ifa.err_cnt), 24);
    wait_lock(nv);
    chk("lock15_words", 32'(nv), 8);

    // Asynchronous reset between edges
    repeat (3) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gen_valid", 32'(ifa.gen_valid), 0);
    chk("arst_gen_data", 32'(ifa.gen_data), 0);
    chk("arst_locked", 32'(ifa.chk_locked), 0);
    chk("arst_err_cnt", 32'(ifa.err_cnt), 0);
    chk("arst_err_sat", 32'(ifb.err_sat), 0);
    chk("sb_drained", 32'(sb.size()), 0);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
